wb_uart_debug_master: RTL

//  Serial debug bridge. Receives byte-level commands on a UART and issues single 32-bit

---
 rtl/wb_dbg_pkg.sv | 32 +++
 rtl/dbg_uart_core.sv | 121 ++++++++++++
 rtl/wb_uart_debug_master.sv | 152 +++++++++++++++
 3 files changed

// File: rtl/wb_dbg_pkg.sv
// Shared constants and state encodings for the UART-to-Wishbone debug bridge.
package wb_dbg_pkg;

  localparam logic [7:0] CMD_WRITE = 8'h57;
  localparam logic [7:0] CMD_READ  = 8'h52;
  localparam logic [7:0] RSP_OK    = 8'h2E;
  localparam logic [7:0] RSP_ERR   = 8'h21;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ADDR,
    ST_DATA,
    ST_BUS,
    ST_RESP
  } dbg_state_e;

  typedef enum logic [2:0] {
    RX_IDLE,
    RX_START,
    RX_DATA,
    RX_STOP,
    RX_BREAK
  } rx_state_e;

  // 16x oversample tick divisor, never below one clock.
  function automatic int uart_div(input int clk_hz, input int bps);
    int d;
    d = clk_hz / (bps * 16);
    return (d < 1) ? 1 : d;
  endfunction

endpackage

// File: rtl/dbg_uart_core.sv
// 8N1 UART with 16x oversampling: byte receiver with framing check and byte transmitter.
module dbg_uart_core
  import wb_dbg_pkg::*;
#(
  parameter int DIV = 54
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       rxd_i,
  output logic       txd_o,
  output logic [7:0] rx_data_o,
  output logic       rx_avail_o,
  input  logic [7:0] tx_data_i,
  input  logic       tx_wr_i,
  output logic       tx_busy_o
);

  localparam int DW = (DIV > 1) ? $clog2(DIV) : 1;

  logic [DW-1:0] div_q;
  logic          tick;
  logic [1:0]    sync_q;
  logic          rxs;
  rx_state_e     rx_st_q;
  logic [3:0]    rx_tk_q;
  logic [2:0]    rx_n_q;
  logic [7:0]    rx_sh_q;
  logic [7:0]    rx_data_q;
  logic          rx_avail_q;
  logic [9:0]    tx_sh_q;
  logic [3:0]    tx_tk_q;
  logic [3:0]    tx_n_q;
  logic          tx_busy_q;

  assign tick       = (div_q == DW'(DIV - 1));
  assign rxs        = sync_q[1];
  assign rx_data_o  = rx_data_q;
  assign rx_avail_o = rx_avail_q;
  assign tx_busy_o  = tx_busy_q;
  assign txd_o      = tx_sh_q[0];

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) div_q <= '0;
    else if (tick) div_q <= '0;
    else           div_q <= div_q + 1'b1;
  end

  // Start edge is re-checked 8 ticks later, then every 16 ticks lands mid-bit.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync_q     <= 2'b11;
      rx_st_q    <= RX_IDLE;
      rx_tk_q    <= '0;
      rx_n_q     <= '0;
      rx_sh_q    <= '0;
      rx_data_q  <= '0;
      rx_avail_q <= 1'b0;
    end else begin
      sync_q     <= {sync_q[0], rxd_i};
      rx_avail_q <= 1'b0;
      if (tick) begin
        case (rx_st_q)
          RX_IDLE: if (!rxs) begin
            rx_st_q <= RX_START;
            rx_tk_q <= '0;
          end
          RX_START: if (rx_tk_q == 4'd7) begin
            rx_tk_q <= '0;
            rx_n_q  <= '0;
            rx_st_q <= rxs ? RX_IDLE : RX_DATA;
          end else rx_tk_q <= rx_tk_q + 4'd1;
          RX_DATA: if (rx_tk_q == 4'd15) begin
            rx_tk_q <= '0;
            rx_sh_q <= {rxs, rx_sh_q[7:1]};
            rx_n_q  <= rx_n_q + 3'd1;
            if (rx_n_q == 3'd7) rx_st_q <= RX_STOP;
          end else rx_tk_q <= rx_tk_q + 4'd1;
          RX_STOP: if (rx_tk_q == 4'd15) begin
            rx_tk_q <= '0;
            if (rxs) begin
              rx_data_q  <= rx_sh_q;
              rx_avail_q <= 1'b1;
              rx_st_q    <= RX_IDLE;
            end else begin
              rx_st_q <= RX_BREAK;
            end
          end else rx_tk_q <= rx_tk_q + 4'd1;
          // A bad stop bit must see the line idle again before hunting for a start.
          RX_BREAK: if (rxs) rx_st_q <= RX_IDLE;
          default:  rx_st_q <= RX_IDLE;
        endcase
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      tx_sh_q   <= '1;
      tx_tk_q   <= '0;
      tx_n_q    <= '0;
      tx_busy_q <= 1'b0;
    end else if (!tx_busy_q) begin
      if (tx_wr_i) begin
        tx_sh_q   <= {1'b1, tx_data_i, 1'b0};
        tx_tk_q   <= '0;
        tx_n_q    <= '0;
        tx_busy_q <= 1'b1;
      end
    end else if (tick) begin
      if (tx_tk_q == 4'd15) begin
        tx_tk_q <= '0;
        tx_sh_q <= {1'b1, tx_sh_q[9:1]};
        if (tx_n_q == 4'd9) tx_busy_q <= 1'b0;
        else                tx_n_q    <= tx_n_q + 4'd1;
      end else begin
        tx_tk_q <= tx_tk_q + 4'd1;
      end
    end
  end

endmodule

// File: rtl/wb_uart_debug_master.sv
// Serial debug bridge: UART command frames become single 32-bit Wishbone cycles.
module wb_uart_debug_master
  import wb_dbg_pkg::*;
#(
  parameter int clk_freq     = 100000000,
  parameter int baud         = 115200,
  parameter int wb_timeout   = 1023,
  parameter int byte_timeout = 1000000
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        uart_rxd,
  output logic        uart_txd,
  output logic [31:0] wb_adr_o,
  output logic [31:0] wb_dat_o,
  input  logic [31:0] wb_dat_i,
  output logic [3:0]  wb_sel_o,
  output logic        wb_we_o,
  output logic        wb_cyc_o,
  output logic        wb_stb_o,
  input  logic        wb_ack_i,
  input  logic        wb_err_i,
  output logic        busy
);

  localparam int DIV = uart_div(clk_freq, baud);
  localparam int WTW = (wb_timeout > 0) ? $clog2(wb_timeout + 1) : 1;
  localparam int BTW = (byte_timeout > 0) ? $clog2(byte_timeout + 1) : 1;

  logic [7:0]     rx_data;
  logic           rx_avail;
  logic           tx_busy;
  dbg_state_e     state_q;
  logic           is_wr_q;
  logic [31:0]    adr_q;
  logic [31:0]    dat_q;
  logic [1:0]     bcnt_q;
  logic [2:0]     rcnt_q;
  logic [BTW-1:0] bto_q;
  logic [WTW-1:0] wto_q;
  logic           cyc_q;
  logic           we_q;
  logic           busy_q;
  logic           tx_wr_q;
  logic [7:0]     tx_data_q;

  dbg_uart_core #(.DIV(DIV)) u_uart (
    .clk        (clk),
    .reset_n    (reset_n),
    .rxd_i      (uart_rxd),
    .txd_o      (uart_txd),
    .rx_data_o  (rx_data),
    .rx_avail_o (rx_avail),
    .tx_data_i  (tx_data_q),
    .tx_wr_i    (tx_wr_q),
    .tx_busy_o  (tx_busy)
  );

  assign wb_adr_o = adr_q;
  assign wb_dat_o = dat_q;
  assign wb_sel_o = {4{cyc_q}};
  assign wb_we_o  = we_q;
  assign wb_cyc_o = cyc_q;
  assign wb_stb_o = cyc_q;
  assign busy     = busy_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= ST_IDLE;
      is_wr_q   <= 1'b0;
      adr_q     <= '0;
      dat_q     <= '0;
      bcnt_q    <= '0;
      rcnt_q    <= '0;
      bto_q     <= '0;
      wto_q     <= '0;
      cyc_q     <= 1'b0;
      we_q      <= 1'b0;
      busy_q    <= 1'b0;
      tx_wr_q   <= 1'b0;
      tx_data_q <= '0;
    end else begin
      case (state_q)
        ST_IDLE: if (rx_avail && (rx_data == CMD_WRITE || rx_data == CMD_READ)) begin
          is_wr_q <= (rx_data == CMD_WRITE);
          bcnt_q  <= '0;
          bto_q   <= '0;
          busy_q  <= 1'b1;
          state_q <= ST_ADDR;
        end
        ST_ADDR, ST_DATA: begin
          if (rx_avail) begin
            bto_q  <= '0;
            bcnt_q <= bcnt_q + 2'd1;
            if (state_q == ST_ADDR) adr_q <= {adr_q[23:0], rx_data};
            else                    dat_q <= {dat_q[23:0], rx_data};
            if (bcnt_q == 2'd3) begin
              if (state_q == ST_ADDR && is_wr_q) begin
                state_q <= ST_DATA;
              end else begin
                state_q <= ST_BUS;
                cyc_q   <= 1'b1;
                we_q    <= is_wr_q;
                wto_q   <= '0;
              end
            end
          end else if (bto_q == BTW'(byte_timeout)) begin
            state_q <= ST_IDLE;
            busy_q  <= 1'b0;
          end else begin
            bto_q <= bto_q + 1'b1;
          end
        end
        // dat_q doubles as the response shift register once the bus cycle ends.
        ST_BUS: begin
          if (wb_ack_i || wb_err_i || wto_q == WTW'(wb_timeout)) begin
            cyc_q   <= 1'b0;
            we_q    <= 1'b0;
            state_q <= ST_RESP;
            if (wb_ack_i && !is_wr_q) begin
              dat_q  <= wb_dat_i;
              rcnt_q <= 3'd4;
            end else begin
              dat_q  <= {(wb_ack_i ? RSP_OK : RSP_ERR), 24'h0};
              rcnt_q <= 3'd1;
            end
          end else begin
            wto_q <= wto_q + 1'b1;
          end
        end
        // tx_busy lags tx_wr by one cycle, so skip the cycle the write is presented.
        ST_RESP: begin
          if (tx_wr_q) begin
            tx_wr_q <= 1'b0;
          end else if (!tx_busy) begin
            if (rcnt_q != 3'd0) begin
              tx_data_q <= dat_q[31:24];
              dat_q     <= {dat_q[23:0], 8'h0};
              rcnt_q    <= rcnt_q - 3'd1;
              tx_wr_q   <= 1'b1;
            end else begin
              state_q <= ST_IDLE;
              busy_q  <= 1'b0;
            end
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

endmodule
